decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  - RV32I instruction decode (stage 2). Consumes the PC, instruction word and bubble flag from fetch.
//  - Drives register-file read addresses and produces one registered decode bundle for execute.
//  - Detects load-use hazards and stalls fetch back-pressure; flushed by a writeback-taken jump.
// PARAMETERS
//  LOAD_USE_STALL  1  1: load-use interlock active; 0: no hazard check, stall_out_d = stall_in_d
// PORTS
//  clk          in   1   clock; all state on rising edge
//  rst          in   1   one clock; reset is synchronous and active-high
//  f_pc         in   32  instruction address from fetch output register
//  f_instr      in   32  instruction word for f_pc
//  f_bubble     in   1   fetch data invalid this cycle (fetch stall-out); treat input as bubble
//  flush        in   1   jump taken in writeback; kill in-flight decode
//  stall_in_d   in   1   execute cannot accept; hold output register
//  stall_out_d  out  1   stall to fetch (drives fetch stall-in)
//  rf_rs1_addr  out  5   combinational rs1 field of f_instr (0 if unused by format)
//  rf_rs2_addr  out  5   combinational rs2 field of f_instr (0 if unused by format)
//  d_valid      out  1   output bundle holds a real instruction
//  d_pc         out  32  registered PC
//  d_rs1/d_rs2  out  5   registered source regs; d_rd out 5 dest reg (0 when no write)
//  d_imm        out  32  sign-extended immediate (I/S/B/U/J formats), 0 for R-type
//  d_alu_op     out  5   0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND 10 PASS_B; 16-23 M ops
//  d_ctrl       out  12  [2:0] funct3 [3] reg_wr [4] mem_rd [5] mem_wr [6] src_a_pc [7] src_b_imm
//                        [8] branch [9] jal [10] jalr [11] illegal
// BEHAVIOUR
//  - Decode is combinational from f_instr; results captured into the output register: latency 1 cycle.
//  - Register update priority per edge: rst > flush > stall_in_d > hazard > capture.
//  - rst: d_valid=0, d_pc=0, d_rs1/d_rs2/d_rd=0, d_imm=0, d_alu_op=0, d_ctrl=0. stall_out_d is combinational, 0 while rst high.
//  - flush: d_valid<=0, all other outputs <=0; flush wins over simultaneous stall_in_d and hazard.
//  - stall_in_d (no flush): every output register holds its value.
//  - hazard = LOAD_USE_STALL & ~f_bubble & d_valid & d_ctrl[4] & d_rd!=0 & ((uses_rs1 & rs1==d_rd) | (uses_rs2 & rs2==d_rd)).
//  - hazard (no flush, no stall_in_d): bubble inserted (d_valid<=0, d_ctrl<=0), fetch held.
//  - Hazard clears next cycle because d_valid drops. Load-use always costs exactly 1 bubble.
//  - capture: d_valid <= ~f_bubble; on f_bubble all fields <=0 (bubble = NOP).
//  - stall_out_d = ~flush & (stall_in_d | hazard).
//  - uses_rs1: R/I/S/B/JALR. uses_rs2: R/S/B. LUI/AUIPC/JAL read no sources (rf addr 0).
//  - LUI: ALU PASS_B, imm={instr[31:12],12'b0}. AUIPC: src_a_pc=1, ADD. JAL/JALR: reg_wr=1, rd=link.
//  - OP-IMM: SRAI selected by instr[30]. SUB/SRA (R-type) selected by instr[30].
//  - d_rd is forced 0 when reg_wr=0. Writes to x0 keep reg_wr=1, rd=0 (harmless).
//  - Illegal: unknown opcode, bad funct3/funct7, or instr[1:0]!=2'b11.
//  - On illegal: d_ctrl[11]=1, reg_wr/mem_rd/mem_wr/branch/jal/jalr=0, d_valid=1 (execute traps).
//  - FENCE/ECALL/EBREAK decode as valid NOP (all ctrl 0 except funct3).
// CONFIGURATION
//  DECODE_M_EXT_EN defined: OP with funct7=0000001 decodes MUL..REMU as d_alu_op 16+funct3, reg_wr=1.
//  DECODE_M_EXT_EN undefined: same encodings flag illegal (d_ctrl[11]=1, reg_wr=0); alu_op 16-23 never produced.
// TESTING
//  ADDI x5,x1,-1 (0xFFF08293), f_pc=0x100 -> next cycle d_valid=1, d_pc=0x100, d_rd=5, d_imm=0xFFFFFFFF, d_alu_op=0, d_ctrl[7]=1.
//  LW x3,0(x2) then ADD x4,x3,x1 -> stall_out_d=1 one cycle, one d_valid=0 bubble, then ADD with d_rs1=3.
//  LW x0,0(x2) then ADD x4,x0,x1 -> no stall (rd=0); LW x3 then LUI x3 -> no stall (no rs use).
//  stall_in_d=1 for 3 cycles holding BEQ -> outputs unchanged; flush with stall_in_d=1 -> d_valid=0 next cycle.
//  f_bubble=1 with f_instr=0x00000013 -> d_valid=0, d_ctrl=0; rst mid-stream -> all outputs 0 next edge.
//  MUL x1,x2,x3 (0x023100B3) -> with DECODE_M_EXT_EN d_alu_op=16, reg_wr=1; without, d_ctrl[11]=1, reg_wr=0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode (pipeline stage 2) with a load-use interlock.
// Define DECODE_M_EXT_EN to decode RV32M (MUL..REMU); otherwise those encodings are illegal.
module decode_stage #(
   parameter bit LOAD_USE_STALL = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] f_pc,
   input  logic [31:0] f_instr,
   input  logic        f_bubble,
   input  logic        flush,
   input  logic        stall_in_d,
   output logic        stall_out_d,
   output logic [4:0]  rf_rs1_addr,
   output logic [4:0]  rf_rs2_addr,
   output logic        d_valid,
   output logic [31:0] d_pc,
   output logic [4:0]  d_rs1,
   output logic [4:0]  d_rs2,
   output logic [4:0]  d_rd,
   output logic [31:0] d_imm,
   output logic [4:0]  d_alu_op,
   output logic [11:0] d_ctrl
);

   typedef enum logic [6:0] {
      OPC_LOAD     = 7'b0000011,
      OPC_MISC_MEM = 7'b0001111,
      OPC_OP_IMM   = 7'b0010011,
      OPC_AUIPC    = 7'b0010111,
      OPC_STORE    = 7'b0100011,
      OPC_OP       = 7'b0110011,
      OPC_LUI      = 7'b0110111,
      OPC_BRANCH   = 7'b1100011,
      OPC_JALR     = 7'b1100111,
      OPC_JAL      = 7'b1101111,
      OPC_SYSTEM   = 7'b1110011
   } opcode_t;

   typedef enum logic [4:0] {
      ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3, ALU_SLTU = 5'd4,
      ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7, ALU_OR = 5'd8, ALU_AND = 5'd9,
      ALU_PASS_B = 5'd10
   } alu_op_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [4:0]  alu_op;
      logic [11:0] ctrl;
   } bundle_t;

   function automatic logic [4:0] alu_base(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   logic [6:0]  funct7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        uses_rs1, uses_rs2, illegal, reg_wr, mem_rd, mem_wr;
   logic        src_a_pc, src_b_imm, branch, jal, jalr, has_f3;
   logic [31:0] imm;
   logic [4:0]  alu_op;
   logic        hazard;
   bundle_t     next_q, bundle_q;

   assign funct7 = f_instr[31:25];
   assign f3     = f_instr[14:12];
   assign imm_i  = {{20{f_instr[31]}}, f_instr[31:20]};
   assign imm_s  = {{20{f_instr[31]}}, f_instr[31:25], f_instr[11:7]};
   assign imm_b  = {{19{f_instr[31]}}, f_instr[31], f_instr[7], f_instr[30:25], f_instr[11:8], 1'b0};
   assign imm_u  = {f_instr[31:12], 12'b0};
   assign imm_j  = {{11{f_instr[31]}}, f_instr[31], f_instr[19:12], f_instr[20], f_instr[30:21], 1'b0};

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      illegal   = 1'b0;
      reg_wr    = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      src_a_pc  = 1'b0;
      src_b_imm = 1'b0;
      branch    = 1'b0;
      jal       = 1'b0;
      jalr      = 1'b0;
      has_f3    = 1'b1;
      imm       = '0;
      alu_op    = ALU_ADD;
      case (f_instr[6:0])
         OPC_LUI: begin
            reg_wr = 1'b1; src_b_imm = 1'b1; has_f3 = 1'b0;
            imm = imm_u; alu_op = ALU_PASS_B;
         end
         OPC_AUIPC: begin
            reg_wr = 1'b1; src_a_pc = 1'b1; src_b_imm = 1'b1; has_f3 = 1'b0; imm = imm_u;
         end
         OPC_JAL: begin
            reg_wr = 1'b1; jal = 1'b1; src_a_pc = 1'b1; src_b_imm = 1'b1; has_f3 = 1'b0; imm = imm_j;
         end
         OPC_JALR: begin
            reg_wr = 1'b1; jalr = 1'b1; uses_rs1 = 1'b1; src_b_imm = 1'b1; imm = imm_i;
            illegal = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = imm_b;
            illegal = (f3[2:1] == 2'b01);
            alu_op  = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
         end
         OPC_LOAD: begin
            reg_wr = 1'b1; mem_rd = 1'b1; uses_rs1 = 1'b1; src_b_imm = 1'b1; imm = imm_i;
            illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         OPC_STORE: begin
            mem_wr = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; src_b_imm = 1'b1; imm = imm_s;
            illegal = (f3 > 3'b010);
         end
         OPC_OP_IMM: begin
            reg_wr = 1'b1; uses_rs1 = 1'b1; src_b_imm = 1'b1; imm = imm_i;
            alu_op = alu_base(f3);
            if (f3 == 3'b001) begin
               illegal = (funct7 != 7'b0000000);
            end else if (f3 == 3'b101) begin
               illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
               if (f_instr[30]) alu_op = ALU_SRA;
            end
         end
         OPC_OP: begin
            reg_wr = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            if (funct7 == 7'b0000000)                      alu_op = alu_base(f3);
            else if (funct7 == 7'b0100000 && f3 == 3'b000) alu_op = ALU_SUB;
            else if (funct7 == 7'b0100000 && f3 == 3'b101) alu_op = ALU_SRA;
`ifdef DECODE_M_EXT_EN
            else if (funct7 == 7'b0000001)                 alu_op = 5'd16 + {2'b00, f3};
`endif
            else                                           illegal = 1'b1;
         end
         OPC_MISC_MEM: illegal = (f3[2:1] != 2'b00);
         OPC_SYSTEM:   illegal = (f3 != 3'b000);
         default:      illegal = 1'b1;
      endcase
      // Illegal words travel as inert trap markers: no side effects, no operands.
      if (illegal) begin
         uses_rs1 = 1'b0; uses_rs2 = 1'b0; reg_wr = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
         src_a_pc = 1'b0; src_b_imm = 1'b0; branch = 1'b0; jal = 1'b0; jalr = 1'b0;
         has_f3 = 1'b0; imm = '0; alu_op = ALU_ADD;
      end
   end

   assign rf_rs1_addr = uses_rs1 ? f_instr[19:15] : 5'd0;
   assign rf_rs2_addr = uses_rs2 ? f_instr[24:20] : 5'd0;

   always_comb begin
      next_q        = '0;
      next_q.valid  = 1'b1;
      next_q.pc     = f_pc;
      next_q.rs1    = rf_rs1_addr;
      next_q.rs2    = rf_rs2_addr;
      next_q.rd     = reg_wr ? f_instr[11:7] : 5'd0;
      next_q.imm    = imm;
      next_q.alu_op = alu_op;
      next_q.ctrl   = {illegal, jalr, jal, branch, src_b_imm, src_a_pc, mem_wr, mem_rd, reg_wr,
                       has_f3 ? f3 : 3'b000};
   end

   assign hazard = LOAD_USE_STALL && !f_bubble && bundle_q.valid && bundle_q.ctrl[4] &&
                   (bundle_q.rd != 5'd0) &&
                   ((uses_rs1 && rf_rs1_addr == bundle_q.rd) ||
                    (uses_rs2 && rf_rs2_addr == bundle_q.rd));

   assign stall_out_d = !rst && !flush && (stall_in_d || hazard);

   // A hazard bubble and a fetch bubble both load an all-zero NOP bundle.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         bundle_q <= '0;
      end else if (!stall_in_d) begin
         if (hazard || f_bubble) bundle_q <= '0;
         else                    bundle_q <= next_q;
      end
   end

   assign d_valid  = bundle_q.valid;
   assign d_pc     = bundle_q.pc;
   assign d_rs1    = bundle_q.rs1;
   assign d_rs2    = bundle_q.rs2;
   assign d_rd     = bundle_q.rd;
   assign d_imm    = bundle_q.imm;
   assign d_alu_op = bundle_q.alu_op;
   assign d_ctrl   = bundle_q.ctrl;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven vectors plus hand sequences for stall, hazard, flush and reset,
// with expected bundles queued at drive time and compared when the register updates.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst, f_bubble, flush, stall_in_d, stall_out_d, d_valid;
   logic [31:0] f_pc, f_instr, d_pc, d_imm;
   logic [4:0]  rf_rs1_addr, rf_rs2_addr, d_rs1, d_rs2, d_rd, d_alu_op;
   logic [11:0] d_ctrl;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst(rst), .f_pc(f_pc), .f_instr(f_instr), .f_bubble(f_bubble),
      .flush(flush), .stall_in_d(stall_in_d), .stall_out_d(stall_out_d),
      .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr), .d_valid(d_valid), .d_pc(d_pc),
      .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_imm(d_imm), .d_alu_op(d_alu_op),
      .d_ctrl(d_ctrl)
   );

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [4:0]  alu;
      logic [11:0] ctrl;
      logic        vc_only;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic        bubble;
      exp_t        e;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] imm,
                               input logic [4:0] alu, input logic [11:0] ctrl);
      exp_t e;
      e.valid = v; e.pc = '0; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
      e.imm = imm; e.alu = alu; e.ctrl = ctrl; e.vc_only = 1'b0;
      return e;
   endfunction

   function automatic exp_t with_pc(input exp_t e, input logic [31:0] pc);
      exp_t r;
      r = e;
      r.pc = pc;
      return r;
   endfunction

   task automatic add_vec(input string n, input logic [31:0] ins, input logic bub, input exp_t e);
      vec_t v;
      v.name = n; v.instr = ins; v.bubble = bub; v.e = e;
      vecs.push_back(v);
   endtask

   task automatic compare_out(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         check({name, " scoreboard_empty"}, 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      check({name, " d_valid"}, {31'b0, d_valid}, {31'b0, e.valid});
      check({name, " d_ctrl"}, {20'b0, d_ctrl}, {20'b0, e.ctrl});
      if (!e.vc_only) begin
         check({name, " d_pc"}, d_pc, e.pc);
         check({name, " d_rs1"}, {27'b0, d_rs1}, {27'b0, e.rs1});
         check({name, " d_rs2"}, {27'b0, d_rs2}, {27'b0, e.rs2});
         check({name, " d_rd"}, {27'b0, d_rd}, {27'b0, e.rd});
         check({name, " d_imm"}, d_imm, e.imm);
         check({name, " d_alu_op"}, {27'b0, d_alu_op}, {27'b0, e.alu});
      end
   endtask

   // Drive one cycle of inputs (from a negedge), check combinational outputs, then the register.
   task automatic apply(input string name, input logic [31:0] instr, input logic [31:0] pc,
                        input logic bub, input logic st, input logic fl, input logic rs,
                        input logic exp_stall, input logic chk_rf, input exp_t e);
      f_instr = instr; f_pc = pc; f_bubble = bub; stall_in_d = st; flush = fl; rst = rs;
      #1;
      check({name, " stall_out_d"}, {31'b0, stall_out_d}, {31'b0, exp_stall});
      if (chk_rf) begin
         check({name, " rf_rs1_addr"}, {27'b0, rf_rs1_addr}, {27'b0, e.rs1});
         check({name, " rf_rs2_addr"}, {27'b0, rf_rs2_addr}, {27'b0, e.rs2});
      end
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      compare_out(name);
   endtask

   localparam logic [31:0] I_ADDI  = 32'hFFF08293;  // addi x5,x1,-1
   localparam logic [31:0] I_ADD   = 32'h00118233;  // add  x4,x3,x1
   localparam logic [31:0] I_ADD0  = 32'h00100233;  // add  x4,x0,x1
   localparam logic [31:0] I_LW3   = 32'h00012183;  // lw   x3,0(x2)
   localparam logic [31:0] I_LW0   = 32'h00012003;  // lw   x0,0(x2)
   localparam logic [31:0] I_LUI3  = 32'h123451B7;  // lui  x3,0x12345
   localparam logic [31:0] I_BEQ   = 32'hFE208EE3;  // beq  x1,x2,-4
   localparam logic [31:0] I_MUL   = 32'h023100B3;  // mul  x1,x2,x3

   initial begin
      exp_t zero_e, bub_e, e_lw3, e_add, e_lui3, e_beq, e_addi, e_mul;

      zero_e = mk(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 5'd0, 12'h000);
      bub_e  = zero_e;
      bub_e.vc_only = 1'b1;
      e_addi = mk(1'b1, 5'd1, 5'd0, 5'd5, 32'hFFFFFFFF, 5'd0, 12'h088);
      e_add  = mk(1'b1, 5'd3, 5'd1, 5'd4, 32'h0, 5'd0, 12'h008);
      e_lw3  = mk(1'b1, 5'd2, 5'd0, 5'd3, 32'h0, 5'd0, 12'h09A);
      e_lui3 = mk(1'b1, 5'd0, 5'd0, 5'd3, 32'h12345000, 5'd10, 12'h088);
      e_beq  = mk(1'b1, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 5'd1, 12'h100);
`ifdef DECODE_M_EXT_EN
      e_mul  = mk(1'b1, 5'd2, 5'd3, 5'd1, 32'h0, 5'd16, 12'h008);
`else
      e_mul  = mk(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 5'd0, 12'h800);
`endif

      add_vec("addi",    I_ADDI,       1'b0, e_addi);
      add_vec("add",     I_ADD,        1'b0, e_add);
      add_vec("sub",     32'h40838333, 1'b0, mk(1'b1, 5'd7, 5'd8, 5'd6, 32'h0, 5'd1, 12'h008));
      add_vec("srai",    32'h40355493, 1'b0, mk(1'b1, 5'd10, 5'd0, 5'd9, 32'h403, 5'd7, 12'h08D));
      add_vec("lui",     I_LUI3,       1'b0, e_lui3);
      add_vec("auipc",   32'hFFFFF397, 1'b0, mk(1'b1, 5'd0, 5'd0, 5'd7, 32'hFFFFF000, 5'd0, 12'h0C8));
      add_vec("sw",      32'h00512423, 1'b0, mk(1'b1, 5'd2, 5'd5, 5'd0, 32'h8, 5'd0, 12'h0A2));
      add_vec("beq",     I_BEQ,        1'b0, e_beq);
      add_vec("jal",     32'h010000EF, 1'b0, mk(1'b1, 5'd0, 5'd0, 5'd1, 32'h10, 5'd0, 12'h2C8));
      add_vec("jalr_x0", 32'h00008067, 1'b0, mk(1'b1, 5'd1, 5'd0, 5'd0, 32'h0, 5'd0, 12'h488));
      add_vec("bad_opc", 32'hFFFFFFFF, 1'b0, mk(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 5'd0, 12'h800));
      add_vec("bad_len", 32'h00000000, 1'b0, mk(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 5'd0, 12'h800));
      add_vec("bad_sll", 32'h40109093, 1'b0, mk(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 5'd0, 12'h800));
      add_vec("lw",      I_LW3,        1'b0, e_lw3);
      add_vec("bubble",  32'h00000013, 1'b1, zero_e);
      add_vec("ecall",   32'h00000073, 1'b0, mk(1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 5'd0, 12'h000));
      add_vec("mul",     I_MUL,        1'b0, e_mul);

      rst = 1'b1; f_pc = '0; f_instr = '0; f_bubble = 1'b0; flush = 1'b0; stall_in_d = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Reset wins over stall and forces the stall output low.
      apply("reset", I_ADDI, 32'h100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, zero_e);

      for (int i = 0; i < vecs.size(); i++) begin
         logic [31:0] pc;
         exp_t        e;
         pc = 32'h100 + 32'(4 * i);
         e  = vecs[i].e;
         if (!vecs[i].bubble) e.pc = pc;
         apply(vecs[i].name, vecs[i].instr, pc, vecs[i].bubble, 1'b0, 1'b0, 1'b0, 1'b0,
               !vecs[i].bubble && !e.ctrl[11], e);
      end

      // Load into x0 never interlocks.
      apply("lw_x0", I_LW0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            with_pc(mk(1'b1, 5'd2, 5'd0, 5'd0, 32'h0, 5'd0, 12'h09A), 32'h200));
      apply("add_x0", I_ADD0, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            with_pc(mk(1'b1, 5'd0, 5'd1, 5'd4, 32'h0, 5'd0, 12'h008), 32'h204));

      // LUI reads no source, so a preceding load of the same register is harmless.
      apply("lw_lui", I_LW3, 32'h210, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, with_pc(e_lw3, 32'h210));
      apply("lui_after_lw", I_LUI3, 32'h214, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            with_pc(e_lui3, 32'h214));

      // Load-use: one stall cycle, one bubble, then the consumer.
      apply("lu_load", I_LW3, 32'h220, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, with_pc(e_lw3, 32'h220));
      apply("lu_bubble", I_ADD, 32'h224, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, bub_e);
      apply("lu_use", I_ADD, 32'h224, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, with_pc(e_add, 32'h224));

      // Flush beats a pending load-use hazard.
      apply("fh_load", I_LW3, 32'h230, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, with_pc(e_lw3, 32'h230));
      apply("fh_flush", I_ADD, 32'h234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, zero_e);

      // Execute back-pressure holds BEQ for three cycles, then a flush under stall clears it.
      apply("hold_beq", I_BEQ, 32'h240, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, with_pc(e_beq, 32'h240));
      for (int k = 0; k < 3; k++) begin
         apply("hold", I_ADDI, 32'h244 + 32'(4 * k), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
               with_pc(e_beq, 32'h240));
      end
      apply("flush_stall", I_ADDI, 32'h250, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, zero_e);

      // Reset in mid-stream clears a live bundle.
      apply("pre_rst", I_ADDI, 32'h260, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, with_pc(e_addi, 32'h260));
      apply("mid_rst", I_ADD, 32'h264, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, zero_e);
      apply("post_rst", I_ADDI, 32'h268, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            with_pc(e_addi, 32'h268));

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
